// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of one packed BCD digit.
  localparam int BCD_NIB_W = 4;

  // Double-dabble correction: a digit of 5 or more would exceed 9 after the
  // next doubling, so pre-add 3 to push the carry into the next digit.
  function automatic logic [BCD_NIB_W-1:0] add3_fix(input logic [BCD_NIB_W-1:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

  // Shift counter width; it counts BIN_W-1 down to 0.
  function automatic int cnt_width(input int bin_w);
    return (bin_w > 1) ? $clog2(bin_w) : 1;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Combinational add-3 correction for one BCD digit of the accumulator.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Correct the digit before it is doubled by the next shift.
  always_comb begin
    digit_out = add3_fix(digit_in);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter (shift-and-add-3).
// Handshakes on both sides are valid/ready: a transfer happens on a rising
// edge where valid and ready are both 1. in_ready is high only in IDLE, and
// out_valid only in DONE; a result must be taken before a new value is
// accepted, so DONE always passes through IDLE before the next accept.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int          BIN_W   = 8,
  parameter int          DIGITS  = 2,
  parameter int          MAX_VAL = 99,
  parameter logic [3:0]  ERR_NIB = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  busy
);

  localparam int               BCD_W   = BCD_NIB_W * DIGITS;
  localparam int               CNT_W   = cnt_width(BIN_W);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [BIN_W-1:0]         shreg;
  logic [BCD_W-1:0]         acc;
  logic [BCD_W-1:0]         acc_fix;
  logic [BCD_W+BIN_W-1:0]   shifted;

  // One add-3 corrector per accumulator digit.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_fix (
      .digit_in  (acc[i*BCD_NIB_W +: BCD_NIB_W]),
      .digit_out (acc_fix[i*BCD_NIB_W +: BCD_NIB_W])
    );
  end

  // Corrected accumulator and shift register move left together by one bit;
  // the carry out of the top digit falls off the end.
  always_comb begin
    shifted = {acc_fix, shreg} << 1;
  end

  // Converter FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      acc       <= '0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (bin_in > MAX_BIN) begin
              // Out of range: skip the conversion and present the error pattern.
              bcd_out   <= {DIGITS{ERR_NIB}};
              ovf       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              shreg <= bin_in;
              acc   <= '0;
              cnt   <= CNT_W'(BIN_W - 1);
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc   <= shifted[BCD_W+BIN_W-1 -: BCD_W];
          shreg <= shifted[BIN_W-1:0];
          if (cnt == '0) begin
            bcd_out   <= shifted[BCD_W+BIN_W-1 -: BCD_W];
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // bcd_out is left untouched so the last result stays visible.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 8-bit/2-digit instance and a
// 10-bit/4-digit instance sharing clock and reset.
module tb_bin_to_bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        in_valid8, in_ready8, out_valid8, out_ready8, ovf8, busy8;
  logic [7:0]  bin_in8, bcd_out8;
  logic        in_valid10, in_ready10, out_valid10, out_ready10, ovf10, busy10;
  logic [9:0]  bin_in10;
  logic [15:0] bcd_out10;

  int pass_cnt;
  int total_cnt;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .MAX_VAL(99), .ERR_NIB(4'hA)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .bin_in    (bin_in8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .bcd_out   (bcd_out8),
    .ovf       (ovf8),
    .busy      (busy8)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4), .MAX_VAL(1023), .ERR_NIB(4'hA)) dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid10),
    .in_ready  (in_ready10),
    .bin_in    (bin_in10),
    .out_valid (out_valid10),
    .out_ready (out_ready10),
    .bcd_out   (bcd_out10),
    .ovf       (ovf10),
    .busy      (busy10)
  );

  // ---------------- reference model ----------------
  // Decimal digits by repeated division; out-of-range gives all-A digits.
  function automatic logic [7:0] ref8(input int v);
    int r;
    int x;
    if (v > 99) return 8'hAA;
    r = 0;
    x = v;
    for (int i = 0; i < 2; i++) begin
      r = r + (x % 10) * (16 ** i);
      x = x / 10;
    end
    return 8'(r);
  endfunction

  function automatic logic [15:0] ref16(input int v);
    int r;
    int x;
    if (v > 1023) return 16'hAAAA;
    r = 0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r = r + (x % 10) * (16 ** i);
      x = x / 10;
    end
    return 16'(r);
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1. Latency counts the cycle after the accept
  // edge as cycle 1.
  task automatic run8(input int v, output logic [7:0] bcd, output logic o,
                      output int lat, output logic busy_seen);
    int w;
    w = 0;
    while (!in_ready8 && w < 20) begin @(posedge clk); #1; w++; end
    total_cnt++;
    if (in_ready8 !== 1'b1) $display("FAIL run8_in_ready: got %b want 1", in_ready8);
    else pass_cnt++;
    in_valid8 = 1'b1;
    bin_in8   = 8'(v);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    bin_in8   = 8'($urandom);
    lat       = 1;
    busy_seen = busy8;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      busy_seen = busy_seen | busy8;
    end
    bcd = bcd_out8;
    o   = ovf8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic run10(input int v, output logic [15:0] bcd, output logic o, output int lat);
    int w;
    w = 0;
    while (!in_ready10 && w < 20) begin @(posedge clk); #1; w++; end
    total_cnt++;
    if (in_ready10 !== 1'b1) $display("FAIL run10_in_ready: got %b want 1", in_ready10);
    else pass_cnt++;
    in_valid10 = 1'b1;
    bin_in10   = 10'(v);
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    bin_in10   = 10'($urandom);
    lat = 1;
    while (!out_valid10 && lat < 40) begin @(posedge clk); #1; lat++; end
    bcd = bcd_out10;
    o   = ovf10;
    out_ready10 = 1'b1;
    @(posedge clk); #1;
    out_ready10 = 1'b0;
  endtask

  // One 8-bit conversion scored against the model.
  task automatic check8(input int v, input string tag);
    logic [7:0] bcd;
    logic       o;
    int         lat;
    logic       bs;
    int         exp_lat;
    run8(v, bcd, o, lat, bs);
    exp_lat = (v > 99) ? 1 : 9;
    total_cnt++;
    if (bcd !== ref8(v)) $display("FAIL %s_bcd v=%0d: got %h want %h", tag, v, bcd, ref8(v));
    else pass_cnt++;
    total_cnt++;
    if (o !== (v > 99)) $display("FAIL %s_ovf v=%0d: got %b want %b", tag, v, o, (v > 99));
    else pass_cnt++;
    total_cnt++;
    if (lat != exp_lat) $display("FAIL %s_latency v=%0d: got %0d want %0d", tag, v, lat, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (bs !== (v <= 99)) $display("FAIL %s_busy v=%0d: got %b want %b", tag, v, bs, (v <= 99));
    else pass_cnt++;
  endtask

  task automatic check10(input int v, input string tag);
    logic [15:0] bcd;
    logic        o;
    int          lat;
    run10(v, bcd, o, lat);
    total_cnt++;
    if (bcd !== ref16(v)) $display("FAIL %s_bcd v=%0d: got %h want %h", tag, v, bcd, ref16(v));
    else pass_cnt++;
    total_cnt++;
    if (o !== 1'b0) $display("FAIL %s_ovf v=%0d: got %b want 0", tag, v, o);
    else pass_cnt++;
    total_cnt++;
    if (lat != 11) $display("FAIL %s_latency v=%0d: got %0d want 11", tag, v, lat);
    else pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [3:0] flags;
    // Leave a non-zero result behind, then reset in the middle of a conversion.
    check8(45, "pre_reset");
    in_valid8 = 1'b1;
    bin_in8   = 8'($urandom_range(1, 99));
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    flags = {out_valid8, ovf8, busy8, in_ready8};
    total_cnt++;
    if (flags !== 4'b0001) $display("FAIL reset_flags8: got %b want 0001", flags);
    else pass_cnt++;
    total_cnt++;
    if (bcd_out8 !== 8'h00) $display("FAIL reset_bcd8: got %h want 00", bcd_out8);
    else pass_cnt++;
    flags = {out_valid10, ovf10, busy10, in_ready10};
    total_cnt++;
    if (flags !== 4'b0001 || bcd_out10 !== 16'h0)
      $display("FAIL reset_dut10: flags %b bcd %h want 0001 0000", flags, bcd_out10);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1)
      $display("FAIL reset_hold: out_valid %b in_ready %b want 0 1", out_valid8, in_ready8);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal;
    check8(45, "normal");
    check8(0, "zero");
    check8(99, "max_val");
    for (int i = 0; i < 16; i++) check8(int'($urandom_range(0, 99)), "rand");
  endtask

  task automatic test_overflow;
    check8(100, "ovf_edge");
    check8(255, "ovf_top");
    for (int i = 0; i < 6; i++) check8(int'($urandom_range(100, 255)), "ovf_rand");
  endtask

  task automatic test_back_pressure;
    int lat;
    logic [9:0] obs;
    in_valid8 = 1'b1;
    bin_in8   = 8'd37;
    @(posedge clk); #1;
    // Keep requesting a different value: it must be ignored until IDLE.
    bin_in8 = 8'd21;
    lat = 1;
    while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
    total_cnt++;
    if (bcd_out8 !== 8'h37 || lat != 9)
      $display("FAIL bp_result: got %h lat %0d want 37 lat 9", bcd_out8, lat);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      obs = {out_valid8, in_ready8, bcd_out8};
      total_cnt++;
      if (obs !== {2'b10, 8'h37}) $display("FAIL bp_hold_%0d: got %h want %h", i, obs, {2'b10, 8'h37});
      else pass_cnt++;
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    // Back in IDLE, no same-cycle accept, last result still shown.
    obs = {out_valid8, in_ready8, bcd_out8};
    total_cnt++;
    if (obs !== {2'b01, 8'h37} || busy8 !== 1'b0)
      $display("FAIL bp_release: got %h busy %b want %h busy 0", obs, busy8, {2'b01, 8'h37});
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    bin_in8   = 8'd0;
    total_cnt++;
    if (busy8 !== 1'b1 || in_ready8 !== 1'b0)
      $display("FAIL bp_next_accept: busy %b in_ready %b want 1 0", busy8, in_ready8);
    else pass_cnt++;
    lat = 1;
    while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
    total_cnt++;
    if (bcd_out8 !== 8'h21 || ovf8 !== 1'b0 || lat != 9)
      $display("FAIL bp_second: got %h ovf %b lat %0d want 21 0 9", bcd_out8, ovf8, lat);
    else pass_cnt++;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic seen;
    in_valid8 = 1'b1;
    bin_in8   = 8'd72;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || in_ready8 !== 1'b1)
      $display("FAIL mid_reset: out_valid %b busy %b in_ready %b want 0 0 1", out_valid8, busy8, in_ready8);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid8;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL mid_reset_no_result: out_valid seen %b want 0", seen);
    else pass_cnt++;
    check8(13, "after_reset");
  endtask

  task automatic test_param10;
    check10(1023, "p10_max");
    check10(512, "p10_512");
    check10(0, "p10_zero");
    for (int i = 0; i < 12; i++) check10(int'($urandom_range(0, 1023)), "p10_rand");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    in_valid8   = 1'b0;
    bin_in8     = '0;
    out_ready8  = 1'b0;
    in_valid10  = 1'b0;
    bin_in10    = '0;
    out_ready10 = 1'b0;
    rst_n       = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid8, ovf8, busy8, in_ready8, bcd_out8} !== {4'b0001, 8'h00})
      $display("FAIL power_on_reset: got %b%b%b%b %h want 0001 00",
               out_valid8, ovf8, busy8, in_ready8, bcd_out8);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_normal();
    test_overflow();
    test_back_pressure();
    test_reset_mid();
    test_param10();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
